// File: rtl/mips_pkg.sv
// Shared widths and the fetch buffer entry type for the MIPS front end.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic         clk,
   input  logic         i_reset,
   input  logic         i_flush,
   input  logic         i_push,
   input  fetch_entry_t i_push_data,
   input  logic         i_pop,
   output logic [CW-1:0] o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && !i_flush;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle-latency imem and buffers
// returned words for the decoder; redirects flush all wrong-path work.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_issued_pc;
   logic              r_inflight;
   logic              r_squash;

   logic [CW-1:0]     w_count;
   logic [CW:0]       w_credit;
   logic              w_pop;
   logic              w_push;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_head;

   assign instr_valid = (w_count != '0);
   assign w_pop       = instr_valid && instr_ready;

   // Outstanding work (buffered + in flight) after this cycle's pop must leave room.
   assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
   assign imem_req = !reset && !redirect_valid && (w_credit < (CW+1)'(FIFO_DEPTH));
   assign imem_addr = r_pc;

   assign w_push             = r_inflight && !r_squash && !redirect_valid;
   assign w_push_entry.pc    = r_issued_pc;
   assign w_push_entry.instr = imem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_issued_pc <= '0;
         r_inflight  <= 1'b0;
         r_squash    <= 1'b0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_squash   <= 1'b0;
      end else begin
         r_inflight <= imem_req;
         if (imem_req) begin
            r_pc        <= r_pc + ADDR_W'(4);
            r_issued_pc <= r_pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .i_reset     (reset),
      .i_flush     (redirect_valid),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   // Empty buffer presents a NOP at PC 0 rather than stale storage.
   assign instr    = instr_valid ? w_head.instr : NOP_INSTR;
   assign instr_pc = instr_valid ? w_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: every issued request queues its expected
// {pc, word}; redirect/reset clear the queue; decoder-side output is checked against the head.
module tb_instr_fetch;
   import mips_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int n_checks = 0;
   int n_errors = 0;

   fetch_entry_t q_exp[$];
   int           m_inflight = 0;
   logic [31:0]  exp_pc = RESET_PC;
   logic         mem_pend = 1'b0;
   logic [31:0]  mem_addr = 32'h0;

   instr_fetch #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   // One clock: sample at negedge, update model, then return the imem word after posedge.
   task automatic cycle();
      fetch_entry_t ent;
      @(negedge clk);
      if (reset) begin
         chk("req_in_reset", 32'(imem_req), 32'h0);
         q_exp.delete();
         m_inflight = 0;
         exp_pc     = RESET_PC;
      end else begin
         chk("valid", 32'(instr_valid), 32'(q_exp.size() > m_inflight));
         if (!instr_valid) begin
            chk("instr_empty", instr, NOP_INSTR);
            chk("pc_empty", instr_pc, 32'h0);
         end else if (!redirect_valid && q_exp.size() > 0) begin
            chk("instr", instr, q_exp[0].instr);
            chk("instr_pc", instr_pc, q_exp[0].pc);
            if (instr_ready) void'(q_exp.pop_front());
         end
         chk("req", 32'(imem_req), 32'(!redirect_valid && q_exp.size() < DEPTH));
         if (redirect_valid) begin
            q_exp.delete();
            m_inflight = 0;
            exp_pc     = redirect_pc & ~32'd3;
         end else if (imem_req) begin
            chk("addr", imem_addr, exp_pc);
            ent.pc    = exp_pc;
            ent.instr = exp_pc ^ MEM_KEY;
            q_exp.push_back(ent);
            exp_pc     = exp_pc + 32'd4;
            m_inflight = 1;
         end else begin
            m_inflight = 0;
         end
      end
      mem_pend = imem_req;
      mem_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = mem_pend ? (mem_addr ^ MEM_KEY) : 32'hDEAD_BEEF;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      cycle();
      redirect_valid = 1'b0;
   endtask

   initial begin
      run(2);

      // streaming from reset with the decoder always ready
      reset       = 1'b0;
      instr_ready = 1'b1;
      run(12);

      // single-cycle reset mid-stream; in-flight word must never surface
      pulse_reset();
      run(8);

      // decoder stalled from the start: two requests then back-pressure
      pulse_reset();
      instr_ready = 1'b0;
      run(10);
      instr_ready = 1'b1;
      run(10);

      // redirect while a request is in flight, unaligned target
      pulse_redirect(32'h0000_0103);
      run(8);

      // redirect on a full buffer with the decoder accepting in the same cycle
      instr_ready = 1'b0;
      run(5);
      instr_ready = 1'b1;
      pulse_redirect(32'h0000_2000);
      run(8);

      // PC wrap at the top of the address space
      pulse_redirect(32'hFFFF_FFF8);
      run(6);

      // random ready / redirect / occasional reset
      for (int i = 0; i < 400; i++) begin
         instr_ready    = ($urandom_range(0, 3) != 0);
         reset          = ($urandom_range(0, 63) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom();
         cycle();
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      run(6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
